reg_file_store_ctrlr: RTL and testbench

- Store-side counterpart of the writeback data select path: carries register-file read data out to data memory.
- Accepts a store request from the EX/MEM stage, either store-word or store-byte.
- Store-word issues a single aligned memory write.
- Store-byte runs a read-modify-write sequence, because data memory only supports full-word writes. The pipeline stalls while a store is in flight.

---
 rtl/reg_file_store_ctrlr.sv | 145 ++++++++++++++
 tb/tb_reg_file_store_ctrlr.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_store_ctrlr.sv
// Store-side memory controller: word stores go straight to a full-word write,
// byte stores do a read-modify-write because data memory only takes whole words.
module reg_file_store_ctrlr #(
   parameter int ADDR_WIDTH = 32,
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  w_st_valid,
   input  logic                  w_st_byte,
   input  logic [ADDR_WIDTH-1:0] w_st_addr,
   input  logic [31:0]           w_st_data,
   output logic                  w_st_ready,
   output logic                  w_stall,
   output logic [ADDR_WIDTH-1:0] w_mem_addr,
   output logic                  w_mem_rd_en,
   input  logic [31:0]           w_mem_rdata,
   output logic                  w_mem_wr_en,
   output logic [31:0]           w_mem_wdata,
   output logic                  w_err_misaligned
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      CAP  = 2'd2,
      WR   = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [1:0]            r_offset;
   logic [7:0]            r_byte_data;
   logic                  r_mem_rd_en;
   logic                  r_mem_wr_en;
   logic                  r_err;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [31:0]           r_mem_wdata;

   logic                  w_misaligned;
   logic                  w_capture;
   logic                  w_rd_en_nxt;
   logic                  w_wr_en_nxt;
   logic                  w_err_nxt;
   logic [ADDR_WIDTH-1:0] w_addr_nxt;
   logic [31:0]           w_wdata_nxt;
   logic [1:0]            w_lane;
   logic [31:0]           w_merged;

   // Handshake: a request transfers on a rising edge where w_st_valid and
   // w_st_ready are both high; while busy, w_st_valid is ignored and the
   // upstream stage must hold its request (w_stall=1).
   assign w_st_ready       = (r_state == IDLE);
   assign w_stall          = !w_st_ready;
   assign w_mem_rd_en      = r_mem_rd_en;
   assign w_mem_wr_en      = r_mem_wr_en;
   assign w_mem_addr       = r_mem_addr;
   assign w_mem_wdata      = r_mem_wdata;
   assign w_err_misaligned = r_err;

   assign w_misaligned = !w_st_byte && (w_st_addr[1:0] != 2'b00);

   // Lane index counted from bit 0; big-endian puts offset 0 in the top byte.
   assign w_lane = BIG_ENDIAN ? (2'd3 - r_offset) : r_offset;

   always_comb begin
      w_merged = w_mem_rdata;
      case (w_lane)
         2'd0:    w_merged[7:0]   = r_byte_data;
         2'd1:    w_merged[15:8]  = r_byte_data;
         2'd2:    w_merged[23:16] = r_byte_data;
         default: w_merged[31:24] = r_byte_data;
      endcase
   end

   always_comb begin
      w_next_state = r_state;
      w_capture    = 1'b0;
      w_rd_en_nxt  = 1'b0;
      w_wr_en_nxt  = 1'b0;
      w_err_nxt    = 1'b0;
      w_addr_nxt   = r_mem_addr;
      w_wdata_nxt  = r_mem_wdata;
      case (r_state)
         IDLE: begin
            if (w_st_valid) begin
               if (w_misaligned) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_capture  = 1'b1;
                  w_addr_nxt = {w_st_addr[ADDR_WIDTH-1:2], 2'b00};
                  if (w_st_byte) begin
                     w_next_state = RD;
                     w_rd_en_nxt  = 1'b1;
                  end else begin
                     w_next_state = WR;
                     w_wr_en_nxt  = 1'b1;
                     w_wdata_nxt  = w_st_data;
                  end
               end
            end
         end
         RD: begin
            w_next_state = CAP;
         end
         CAP: begin
            // Read data is valid this cycle; the merged word is written next.
            w_next_state = WR;
            w_wr_en_nxt  = 1'b1;
            w_wdata_nxt  = w_merged;
         end
         WR: begin
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_offset    <= 2'b00;
         r_byte_data <= 8'h00;
         r_mem_rd_en <= 1'b0;
         r_mem_wr_en <= 1'b0;
         r_err       <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= 32'h0;
      end else begin
         r_state     <= w_next_state;
         r_mem_rd_en <= w_rd_en_nxt;
         r_mem_wr_en <= w_wr_en_nxt;
         r_err       <= w_err_nxt;
         r_mem_addr  <= w_addr_nxt;
         r_mem_wdata <= w_wdata_nxt;
         if (w_capture) begin
            r_offset    <= w_st_addr[1:0];
            r_byte_data <= w_st_data[7:0];
         end
      end
   end

endmodule

// File: tb/tb_reg_file_store_ctrlr.sv
// Bench for reg_file_store_ctrlr: a big-endian and a little-endian instance share
// stimulus; expected words come from byte-addressed reference memories.
module tb_reg_file_store_ctrlr;

   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          st_valid;
   logic          st_byte;
   logic [AW-1:0] st_addr;
   logic [31:0]   st_data;

   logic          be_ready, be_stall, be_rd, be_wr, be_err;
   logic [AW-1:0] be_maddr;
   logic [31:0]   be_rdata, be_wdata;
   logic          le_ready, le_stall, le_rd, le_wr, le_err;
   logic [AW-1:0] le_maddr;
   logic [31:0]   le_rdata, le_wdata;

   int checks = 0;
   int errors = 0;

   // Reference: memory contents as bytes, one image per byte order.
   logic [7:0]  ref_be [1024];
   logic [7:0]  ref_le [1024];
   // Word memories the instances actually read and write.
   logic [31:0] mem_be [256];
   logic [31:0] mem_le [256];
   logic [31:0] last_be, last_le;

   always #5 clk = ~clk;

   reg_file_store_ctrlr #(.ADDR_WIDTH(AW), .BIG_ENDIAN(1'b1)) u_be (
      .clock(clk), .reset(rst),
      .w_st_valid(st_valid), .w_st_byte(st_byte), .w_st_addr(st_addr), .w_st_data(st_data),
      .w_st_ready(be_ready), .w_stall(be_stall), .w_mem_addr(be_maddr),
      .w_mem_rd_en(be_rd), .w_mem_rdata(be_rdata), .w_mem_wr_en(be_wr),
      .w_mem_wdata(be_wdata), .w_err_misaligned(be_err)
   );

   reg_file_store_ctrlr #(.ADDR_WIDTH(AW), .BIG_ENDIAN(1'b0)) u_le (
      .clock(clk), .reset(rst),
      .w_st_valid(st_valid), .w_st_byte(st_byte), .w_st_addr(st_addr), .w_st_data(st_data),
      .w_st_ready(le_ready), .w_stall(le_stall), .w_mem_addr(le_maddr),
      .w_mem_rd_en(le_rd), .w_mem_rdata(le_rdata), .w_mem_wr_en(le_wr),
      .w_mem_wdata(le_wdata), .w_err_misaligned(le_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] word_be(input logic [9:0] a);
      return {ref_be[a], ref_be[a + 10'd1], ref_be[a + 10'd2], ref_be[a + 10'd3]};
   endfunction

   function automatic logic [31:0] word_le(input logic [9:0] a);
      return {ref_le[a + 10'd3], ref_le[a + 10'd2], ref_le[a + 10'd1], ref_le[a]};
   endfunction

   task automatic set_word(input logic [9:0] a, input logic [31:0] w);
      mem_be[a[9:2]] = w;
      mem_le[a[9:2]] = w;
      for (int k = 0; k < 4; k++) begin
         ref_be[{a[9:2], 2'(k)}] = w[31 - 8*k -: 8];
         ref_le[{a[9:2], 2'(k)}] = w[8*k +: 8];
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      chk1({tag, "_ready_be"}, be_ready, 1'b1);
      chk1({tag, "_ready_le"}, le_ready, 1'b1);
      chk1({tag, "_stall_be"}, be_stall, 1'b0);
      chk1({tag, "_stall_le"}, le_stall, 1'b0);
   endtask

   // Presents one request (called between edges), then follows it cycle by
   // cycle until the controller is ready again. With junk=1, random requests
   // are driven while busy and must be ignored.
   task automatic store(input logic b, input logic [31:0] a, input logic [31:0] d, input bit junk);
      logic [31:0] al, exp_be, exp_le;
      logic        mis, rd_exp, wr_exp, stall_exp, err_exp;
      int          lat;
      mis = !b && (a[1:0] != 2'b00);
      al  = {a[31:2], 2'b00};
      if (!mis) begin
         if (b) begin
            ref_be[a[9:0]] = d[7:0];
            ref_le[a[9:0]] = d[7:0];
         end else begin
            for (int k = 0; k < 4; k++) begin
               ref_be[{al[9:2], 2'(k)}] = d[31 - 8*k -: 8];
               ref_le[{al[9:2], 2'(k)}] = d[8*k +: 8];
            end
         end
      end
      exp_be = word_be(al[9:0]);
      exp_le = word_le(al[9:0]);
      lat = mis ? 1 : (b ? 4 : 2);

      st_valid = 1'b1;
      st_byte  = b;
      st_addr  = a;
      st_data  = d;
      check_idle_outputs("pre");
      @(posedge clk);
      #1;
      for (int k = 1; k <= lat; k++) begin
         if (k == lat || !junk) begin
            st_valid = 1'b0;
         end else begin
            st_valid = 1'b1;
            st_byte  = 1'($urandom_range(0, 1));
            st_addr  = $urandom_range(0, 1023);
            st_data  = $urandom;
         end
         @(negedge clk);
         rd_exp    = b && !mis && (k == 1);
         wr_exp    = !mis && (k == lat - 1);
         stall_exp = (k < lat);
         err_exp   = mis && (k == 1);
         chk1("rd_en_be", be_rd, rd_exp);
         chk1("rd_en_le", le_rd, rd_exp);
         chk1("wr_en_be", be_wr, wr_exp);
         chk1("wr_en_le", le_wr, wr_exp);
         chk1("stall_be", be_stall, stall_exp);
         chk1("stall_le", le_stall, stall_exp);
         chk1("ready_be", be_ready, !stall_exp);
         chk1("err_be", be_err, err_exp);
         chk1("err_le", le_err, err_exp);
         if (rd_exp) begin
            chk("rd_addr_be", be_maddr, al);
            chk("rd_addr_le", le_maddr, al);
            be_rdata = mem_be[be_maddr[9:2]];
            le_rdata = mem_le[le_maddr[9:2]];
         end
         if (wr_exp) begin
            chk("wr_addr_be", be_maddr, al);
            chk("wr_addr_le", le_maddr, al);
            chk("wdata_be", be_wdata, exp_be);
            chk("wdata_le", le_wdata, exp_le);
            mem_be[be_maddr[9:2]] = be_wdata;
            mem_le[le_maddr[9:2]] = le_wdata;
            last_be = be_wdata;
            last_le = le_wdata;
         end
         if (k < lat) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] a;
      logic        b;

      st_valid = 1'b0;
      st_byte  = 1'b0;
      st_addr  = '0;
      st_data  = '0;
      be_rdata = '0;
      le_rdata = '0;
      last_be  = '0;
      last_le  = '0;
      rst      = 1'b1;
      for (int w = 0; w < 256; w++) set_word(10'(w * 4), $urandom);

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("rst");
      chk1("rst_rd_be", be_rd, 1'b0);
      chk1("rst_wr_le", le_wr, 1'b0);
      chk("rst_addr_be", be_maddr, 32'h0);
      chk("rst_wdata_le", le_wdata, 32'h0);
      chk1("rst_err_be", be_err, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // Word store
      store(1'b0, 32'h100, 32'hDEADBEEF, 1'b0);
      chk("t1_wdata_be", last_be, 32'hDEADBEEF);
      chk("t1_wdata_le", last_le, 32'hDEADBEEF);

      // Byte store into a known word
      set_word(10'h204, 32'h11223344);
      store(1'b1, 32'h205, 32'h000000AB, 1'b0);
      chk("t2_wdata_be", last_be, 32'h11AB3344);
      chk("t2_wdata_le", last_le, 32'h1122AB44);

      // Every offset, upper data bits must be ignored
      for (int off = 0; off < 4; off++) begin
         set_word(10'h300, 32'hFFFFFFFF);
         d = $urandom;
         d[7:0] = 8'h00;
         store(1'b1, 32'h300 + 32'(off), d, 1'b0);
         chk("t3_wdata_be", last_be, ~(32'hFF000000 >> (8 * off)));
         chk("t3_wdata_le", last_le, ~(32'h000000FF << (8 * off)));
      end

      // Misaligned word store is rejected
      store(1'b0, 32'h102, 32'h55555555, 1'b0);
      @(negedge clk);
      chk1("t4_err_clear_be", be_err, 1'b0);
      chk1("t4_wr_be", be_wr, 1'b0);

      // Back-to-back with requests held during busy cycles
      store(1'b0, 32'h040, $urandom, 1'b1);
      store(1'b1, 32'h047, $urandom, 1'b1);
      store(1'b0, 32'h041, $urandom, 1'b1);

      // Randomized stores
      for (int i = 0; i < 60; i++) begin
         b = 1'($urandom_range(0, 1));
         a = $urandom_range(0, 1023);
         if (!b && $urandom_range(0, 9) < 7) a[1:0] = 2'b00;
         store(b, a, $urandom, 1'($urandom_range(0, 1)));
      end

      // Reset during CAP of a byte store
      st_valid = 1'b1;
      st_byte  = 1'b1;
      st_addr  = 32'h3A6;
      st_data  = 32'h000000C3;
      @(posedge clk);
      #1;
      st_valid = 1'b0;
      @(negedge clk);
      chk1("t6_rd_be", be_rd, 1'b1);
      be_rdata = mem_be[be_maddr[9:2]];
      le_rdata = mem_le[le_maddr[9:2]];
      @(posedge clk);
      @(negedge clk);
      chk1("t6_cap_stall_be", be_stall, 1'b1);
      rst = 1'b1;
      #1;
      check_idle_outputs("t6_async");
      chk1("t6_rd0_be", be_rd, 1'b0);
      chk1("t6_wr0_be", be_wr, 1'b0);
      chk1("t6_wr0_le", le_wr, 1'b0);
      chk("t6_addr_be", be_maddr, 32'h0);
      chk("t6_wdata_le", le_wdata, 32'h0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk1("t6_hold_wr_be", be_wr, 1'b0);
         chk1("t6_hold_wr_le", le_wr, 1'b0);
      end
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk1("t6_post_wr_be", be_wr, 1'b0);
         chk1("t6_post_wr_le", le_wr, 1'b0);
         check_idle_outputs("t6_post");
      end

      // Controller still works after the abandoned store
      store(1'b1, 32'h3A6, 32'h0000005A, 1'b0);
      store(1'b0, 32'h3A4, $urandom, 1'b0);

      // Memory images written by the instances must match the byte reference
      for (int w = 0; w < 256; w++) begin
         chk("mem_be", mem_be[w], word_be(10'(w * 4)));
         chk("mem_le", mem_le[w], word_le(10'(w * 4)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
